id_hazard_unit: RTL
===================

# id_hazard_unit

Stall/flush controller for the ID stage of the 5-stage pipeline. It sits beside the forwarding unit that supplies the ID-stage operand selects. It detects the cases forwarding cannot cover: a load-use dependency, or a branch in ID whose operand is not yet forwardable. For these it inserts one or two bubble cycles through a small state machine. It also issues the IF/ID flush for taken branches, freezes the pipe on data-memory stalls, and keeps saturating performance counters.

## Interface
- CNT_W, 32, width of each performance counter
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- IdRs_i, IdRt_i  in  5 each  source registers of the instruction in ID
- IdUsesRs_i, IdUsesRt_i  in  1 each  ID instruction reads Rs / Rt
- IdIsBranch_i  in  1  ID instruction is a branch compared in ID
- BranchTaken_i  in  1  ID branch resolved taken this cycle
- ExRegWrite_i, ExMemRead_i  in  1 each  instruction in EX writes a register / is a load
- ExRegisterRd_i  in  5  destination of the instruction in EX
- MemMemRead_i  in  1  instruction in MEM is a load
- MemRegisterRd_i  in  5  destination of the instruction in MEM
- MemStall_i  in  1  data memory busy; whole pipe must freeze
- PcWrite_o  out  1  PC update enable
- IfIdWrite_o  out  1  IF/ID register write enable
- IdExBubble_o  out  1  load NOP into ID/EX instead of the ID instruction
- IfIdFlush_o  out  1  clear IF/ID (taken branch)
- Freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB
- StallCycles_o, FlushCount_o, FreezeCycles_o  out  CNT_W each  performance counters

## Operation
- Match rules: a match requires the producer Rd to be nonzero and equal to IdRs_i with IdUsesRs_i set, or to IdRt_i with IdUsesRt_i set.
- Required stall length L (take the max of all applicable cases):
  - EX load match, ID branch: L=2.
  - EX load match, ID non-branch: L=1.
  - EX non-load match with ExRegWrite_i, ID branch: L=1.
  - MEM load match, ID branch: L=1.
  - Otherwise L=0.
- State machine states: RUN and HOLD; a 1-bit remaining-count register.
- RUN, L=0: no stall. PcWrite_o=IfIdWrite_o=1, IdExBubble_o=0.
- RUN, L>=1: stall this cycle. PcWrite_o=IfIdWrite_o=0, IdExBubble_o=1.
  - L=2: go to HOLD.
  - L=1: stay in RUN; the next cycle re-evaluates.
- HOLD: stall unconditionally for one cycle, without re-evaluating, then return to RUN.
- IfIdFlush_o = BranchTaken_i while in RUN with L=0 and MemStall_i=0. BranchTaken_i is masked during any stall or freeze.
  - A flush keeps PcWrite_o=1, so the branch target is fetched.
- MemStall_i=1 has highest priority (below reset):
  - Freeze_o=1, PcWrite_o=IfIdWrite_o=0, IdExBubble_o=0, IfIdFlush_o=0.
  - State and remaining count hold.
  - Hazard evaluation is suppressed, and no state transition occurs.
- Counters (each saturates at all-ones, never wraps):
  - StallCycles_o +1 per hazard-stall cycle (RUN with L>=1, or HOLD).
  - FlushCount_o +1 per IfIdFlush_o cycle.
  - FreezeCycles_o +1 per MemStall_i cycle.

## Timing
- Control outputs are combinational from the current state and inputs; no input-to-output latency. State and counters update on the rising edge of clk_i.
- While rst_i=1:
  - Outputs forced: PcWrite_o=0, IfIdWrite_o=0, IdExBubble_o=1, IfIdFlush_o=0, Freeze_o=0.
  - On the clock edge: state becomes RUN, count becomes 0, all counters become 0.
- Reset asserted in HOLD aborts the stall; the first cycle after reset is RUN with a fresh evaluation.
- Load feeding a branch: exactly 2 stall cycles, then the branch resolves in the third cycle.
- Freeze during HOLD: the stall stretches by the number of freeze cycles; HOLD still lasts exactly one non-frozen cycle.
- A Rd of 0 never causes a stall, whatever RegWrite/MemRead say.

## Test plan
- Load-use: EX load with Rd=5; ID add with Rs=5 and IdUsesRs_i=1.
  - Expect 1 cycle of PcWrite_o=0 and IdExBubble_o=1; StallCycles_o 0->1.
- Load then branch: EX load with Rd=8; ID beq with Rt=8.
  - Expect 2 stall cycles (RUN->HOLD->RUN); the third cycle with BranchTaken_i=1 gives IfIdFlush_o=1 and FlushCount_o=1.
- ALU op then branch: EX add with Rd=3; ID beq with Rs=3 → exactly 1 stall.
  - Repeat with Rd=0 → no stall.
- Freeze: MemStall_i=1 for 3 cycles while in HOLD.
  - Expect Freeze_o=1 and all write enables 0; FreezeCycles_o=3; then 1 HOLD stall cycle, then RUN.
- Masking: BranchTaken_i=1 during an L=1 stall → IfIdFlush_o=0.
- Reset and saturation:
  - Assert rst_i in HOLD → next cycle is RUN, counters 0.
  - With CNT_W=4, hold a stall for 20 cycles → StallCycles_o stays at 15.

Source files
------------

// File: rtl/id_hazard_unit.sv
// id_hazard_unit: ID-stage stall/flush/freeze controller with saturating performance counters
module id_hazard_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IdRs_i,
    input  logic [4:0]       IdRt_i,
    input  logic             IdUsesRs_i,
    input  logic             IdUsesRt_i,
    input  logic             IdIsBranch_i,
    input  logic             BranchTaken_i,
    input  logic             ExRegWrite_i,
    input  logic             ExMemRead_i,
    input  logic [4:0]       ExRegisterRd_i,
    input  logic             MemMemRead_i,
    input  logic [4:0]       MemRegisterRd_i,
    input  logic             MemStall_i,
    output logic             PcWrite_o,
    output logic             IfIdWrite_o,
    output logic             IdExBubble_o,
    output logic             IfIdFlush_o,
    output logic             Freeze_o,
    output logic [CNT_W-1:0] StallCycles_o,
    output logic [CNT_W-1:0] FlushCount_o,
    output logic [CNT_W-1:0] FreezeCycles_o
);
    typedef enum logic {RUN, HOLD} state_t;
    state_t r_state, w_next;
    logic r_cnt, w_cnt_next;
    logic w_ex_match, w_mem_match, w_hold, w_stall;
    logic [1:0] w_len;
    assign w_ex_match  = (ExRegisterRd_i != 5'd0) &&
                         ((IdUsesRs_i && ExRegisterRd_i == IdRs_i) || (IdUsesRt_i && ExRegisterRd_i == IdRt_i));
    assign w_mem_match = (MemRegisterRd_i != 5'd0) &&
                         ((IdUsesRs_i && MemRegisterRd_i == IdRs_i) || (IdUsesRt_i && MemRegisterRd_i == IdRt_i));
    assign w_len = (ExMemRead_i && w_ex_match && IdIsBranch_i) ? 2'd2 :
                   ((ExMemRead_i && w_ex_match) ||
                    (ExRegWrite_i && w_ex_match && IdIsBranch_i) ||
                    (MemMemRead_i && w_mem_match && IdIsBranch_i)) ? 2'd1 : 2'd0;
    assign w_hold  = (r_state == HOLD) && r_cnt;
    // HOLD stalls without looking at the hazard inputs
    assign w_stall = !MemStall_i && (w_hold || w_len != 2'd0);
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RUN;
            r_cnt   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end
    always_comb begin
        w_next     = MemStall_i ? r_state : (!w_hold && w_len == 2'd2) ? HOLD : RUN;
        w_cnt_next = MemStall_i ? r_cnt : (!w_hold && w_len == 2'd2);
    end
    always_comb begin
        PcWrite_o    = !rst_i && !MemStall_i && !w_stall;
        IfIdWrite_o  = !rst_i && !MemStall_i && !w_stall;
        IdExBubble_o = rst_i || w_stall;
        IfIdFlush_o  = !rst_i && !MemStall_i && !w_stall && BranchTaken_i;
        Freeze_o     = !rst_i && MemStall_i;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            StallCycles_o  <= '0;
            FlushCount_o   <= '0;
            FreezeCycles_o <= '0;
        end else begin
            if (w_stall && !(&StallCycles_o))
                StallCycles_o <= StallCycles_o + CNT_W'(1);
            if (IfIdFlush_o && !(&FlushCount_o))
                FlushCount_o <= FlushCount_o + CNT_W'(1);
            if (MemStall_i && !(&FreezeCycles_o))
                FreezeCycles_o <= FreezeCycles_o + CNT_W'(1);
        end
    end
endmodule
